// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 program loader: loader states and
// stream-format constants. Used by mips_word_asm and mips_prog_loader.
package mips_pkg;

    localparam int DEF_ADDR_W = 10;  // default memory word-address width
    localparam int WORD_W     = 32;  // instruction word width
    localparam int LEN_BYTES  = 2;   // length prefix size in bytes
    localparam int WORD_BYTES = 4;   // bytes per instruction/checksum word

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/mips_word_asm.sv
// Big-endian byte assembler: shifts accepted bytes in MSB first and flags the
// byte that completes a field. The field length (2 or 4 bytes) is selected per
// byte by i_last_idx, so the same instance captures the length prefix, the
// data words and the checksum.
module mips_word_asm
    import mips_pkg::*;
(
    input  logic              clk1,
    input  logic              rst,
    input  logic              i_en,         // a byte is accepted this cycle
    input  logic [7:0]        i_byte,
    input  logic [1:0]        i_last_idx,   // byte index that completes the field
    output logic [WORD_W-1:0] o_word,       // {previous bytes, current byte}
    output logic              o_word_valid  // one cycle, on the completing byte
);

    logic [WORD_W-9:0] r_shift;
    logic [1:0]        r_idx;

    // The completing byte is folded in combinationally so the caller can
    // register the whole word on the same edge that accepts that byte.
    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_en && (r_idx == i_last_idx);

    // Shift accepted bytes in and track the position within the field.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_en) begin
            r_shift <= {r_shift[WORD_W-17:0], i_byte};
            r_idx   <= o_word_valid ? 2'd0 : r_idx + 2'd1;
        end
    end

endmodule

// File: rtl/mips_prog_loader.sv
// Boot loader top: receives a length-prefixed big-endian program image over a
// valid/ready byte stream, writes the words to memory from address 0 while
// holding the core, then releases it with a one-cycle start pulse.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing 32-bit
// XOR checksum of all data words before the core is released.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              proc_hold,
    output logic              proc_start,
    output logic              load_done,
    output logic              err,
    output logic [15:0]       word_count
);

    localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

    state_t            r_state;
    logic [15:0]       r_len;
    logic [15:0]       r_word_count;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [WORD_W-1:0] r_mem_wdata;  // write holding register
    logic              r_proc_hold;
    logic              r_proc_start;
    logic              r_load_done;
    logic              r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_xor;
`endif

    logic              w_xfer;
    logic [1:0]        w_last_idx;
    logic [WORD_W-1:0] w_word;
    logic              w_word_valid;
    logic              w_len_over;

    assign w_xfer     = in_valid && r_in_ready;
    assign w_last_idx = (r_state == S_LEN) ? 2'(LEN_BYTES - 1) : 2'(WORD_BYTES - 1);
    assign w_len_over = {1'b0, w_word[15:0]} > MAX_LEN;

    mips_word_asm u_word_asm (
        .clk1         (clk1),
        .rst          (rst),
        .i_en         (w_xfer),
        .i_byte       (in_byte),
        .i_last_idx   (w_last_idx),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    assign in_ready   = r_in_ready;
    // A write already sitting in the holding register is squashed as soon as
    // reset is seen, rather than one cycle later when the register clears.
    assign mem_we     = r_mem_we & ~rst;
    assign mem_addr   = r_word_count[ADDR_W-1:0];
    assign mem_wdata  = r_mem_wdata;
    assign proc_hold  = r_proc_hold;
    assign proc_start = r_proc_start;
    assign load_done  = r_load_done;
    assign err        = r_err;
    assign word_count = r_word_count;

    // Load sequencer: length capture, word writes, optional checksum, and the
    // terminal done/error states, with every output registered.
    // NOTE: all state here updates with <= so each branch sees the values from
    // before this edge, regardless of statement order.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state      <= S_LEN;
            r_len        <= '0;
            r_word_count <= '0;
            r_in_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_proc_hold  <= 1'b1;
            r_proc_start <= 1'b0;
            r_load_done  <= 1'b0;
            r_err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor        <= '0;
`endif
        end else begin
            r_mem_we     <= 1'b0;
            r_proc_start <= 1'b0;
            // The count advances with each write and stops at N.
            if (r_mem_we && (r_word_count < r_len))
                r_word_count <= r_word_count + 16'd1;

            case (r_state)
                S_LEN: begin
                    r_in_ready <= 1'b1;
                    if (w_word_valid) begin
                        r_len <= w_word[15:0];
                        if (w_len_over) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end else if (w_word[15:0] == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state <= S_CHK;
`else
                            r_state      <= S_DONE;
                            r_in_ready   <= 1'b0;
                            r_proc_hold  <= 1'b0;
                            r_proc_start <= 1'b1;
                            r_load_done  <= 1'b1;
`endif
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (w_word_valid) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_word;
`ifdef LOADER_CHECKSUM_EN
                        r_xor <= r_xor ^ w_word;
                        // Switch on the last word's final byte so the next
                        // byte already lands in the checksum field.
                        if (r_word_count == r_len - 16'd1)
                            r_state <= S_CHK;
`endif
                    end
`ifndef LOADER_CHECKSUM_EN
                    if (r_mem_we && (r_word_count == r_len - 16'd1)) begin
                        r_state      <= S_DONE;
                        r_in_ready   <= 1'b0;
                        r_proc_hold  <= 1'b0;
                        r_proc_start <= 1'b1;
                        r_load_done  <= 1'b1;
                    end
`endif
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_word_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_word == r_xor) begin
                            r_state      <= S_DONE;
                            r_proc_hold  <= 1'b0;
                            r_proc_start <= 1'b1;
                            r_load_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif

                S_DONE, S_ERR: begin
                    r_in_ready <= 1'b0;
                end

                default: begin
                    r_state    <= S_ERR;
                    r_in_ready <= 1'b0;
                    r_err      <= 1'b1;
                end
            endcase
        end
    end

endmodule
